mem_access_stage: RTL and testbench

- MEM stage of the pipelined OTTER core. Sits between the EX/MEM pipeline register and the WB stage.
- Takes registered EX/MEM control and data and performs RV32I loads and stores on a variable-latency data bus with a REQ/ACK handshake.
- Formats load data and registers the MEM/WB pipeline outputs.
- Stalls upstream stages while a bus access is outstanding.

---
 rtl/mem_access_stage.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage of the pipelined OTTER core: RV32I loads/stores over a REQ/ACK data bus
// with an abort timeout, load-data formatting and the MEM/WB pipeline register.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  SIZE_MEM,
    input  logic        SIGN_MEM,
    input  logic        MEM_READ_2_MEM,
    input  logic        MEM_WRITE_MEM,
    input  logic        REG_WRITE_MEM,
    input  logic        RF_WR_SEL_MEM,
    input  logic [31:0] ALU_RESULT_MEM,
    input  logic [31:0] RS2_MEM,
    input  logic [4:0]  RD_MEM,
    input  logic [31:0] PC_N_MEM,
    output logic        DBUS_REQ,
    output logic        DBUS_WE,
    output logic [31:0] DBUS_ADDR,
    output logic [3:0]  DBUS_BE,
    output logic [31:0] DBUS_WDATA,
    input  logic        DBUS_ACK,
    input  logic [31:0] DBUS_RDATA,
    output logic        STALL,
    output logic        REG_WRITE_WB,
    output logic        RF_WR_SEL_WB,
    output logic [4:0]  RD_WB,
    output logic [31:0] ALU_RESULT_WB,
    output logic [31:0] LOAD_DATA_WB,
    output logic [31:0] PC_N_WB,
    output logic        MISALIGN_ERR,
    output logic        BUS_ERR
);

    typedef enum logic [0:0] { S_IDLE = 1'b0, S_BUSY = 1'b1 } state_t;

    // Counter value seen in the last BUSY cycle before the access is abandoned.
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 32'd1);

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] rs2);
        logic [31:0] wd;
        case (size)
            2'b00:   wd = {4{rs2[7:0]}};
            2'b01:   wd = {2{rs2[15:0]}};
            default: wd = rs2;
        endcase
        return wd;
    endfunction

    function automatic logic [31:0] load_fmt(input logic [1:0] size, input logic zext,
                                             input logic [1:0] off, input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'b00:   b = rdata[7:0];
            2'b01:   b = rdata[15:8];
            2'b10:   b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   r = zext ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   r = zext ? {16'h0000, h} : {{16{h[15]}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    logic        idle_s, acc_s, mis_s, ack_s, timeout_s, start_s, stall_s;
    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  off_q, off_d, size_q, size_d;
    logic        zext_q, zext_d;
    logic        rw_wb_q, rw_wb_d, sel_wb_q, sel_wb_d;
    logic [4:0]  rd_wb_q, rd_wb_d;
    logic [31:0] alu_wb_q, alu_wb_d, ld_wb_q, ld_wb_d, pcn_wb_q, pcn_wb_d;
    logic        mis_err_q, mis_err_d, bus_err_q, bus_err_d;

    // Next-state, bus and MEM/WB register computation.
    always_comb begin
        idle_s    = (state_q == S_IDLE);
        acc_s     = MEM_READ_2_MEM | MEM_WRITE_MEM;
        mis_s     = acc_s & ((SIZE_MEM == 2'b11)
                           | ((SIZE_MEM == 2'b01) & ALU_RESULT_MEM[0])
                           | ((SIZE_MEM == 2'b10) & (ALU_RESULT_MEM[1:0] != 2'b00)));
        ack_s     = ~idle_s & DBUS_ACK;
        timeout_s = ~idle_s & ~DBUS_ACK & (cnt_q == TO_LAST);
        start_s   = idle_s & acc_s & ~mis_s;
        if (idle_s) begin
            stall_s = start_s;
        end else begin
            stall_s = ~DBUS_ACK & ~timeout_s;
        end

        state_d  = state_q;
        cnt_d    = 10'd0;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        off_d    = off_q;
        size_d   = size_q;
        zext_d   = zext_q;
        rw_wb_d  = 1'b0;
        sel_wb_d = sel_wb_q;
        rd_wb_d  = rd_wb_q;
        alu_wb_d = alu_wb_q;
        ld_wb_d  = ld_wb_q;
        pcn_wb_d = pcn_wb_q;

        if (start_s) begin
            state_d = S_BUSY;
            req_d   = 1'b1;
            we_d    = MEM_WRITE_MEM;
            addr_d  = {ALU_RESULT_MEM[31:2], 2'b00};
            be_d    = store_be(SIZE_MEM, ALU_RESULT_MEM[1:0]);
            wdata_d = store_wdata(SIZE_MEM, RS2_MEM);
            off_d   = ALU_RESULT_MEM[1:0];
            size_d  = SIZE_MEM;
            zext_d  = SIGN_MEM;
        end else if (ack_s | timeout_s) begin
            state_d = S_IDLE;
            req_d   = 1'b0;
        end else if (!idle_s) begin
            cnt_d = cnt_q + 10'd1;
        end else begin
            cnt_d = 10'd0;
        end

        // A stalled cycle inserts a bubble; aborted or faulting accesses never write the RF.
        if (!stall_s) begin
            rw_wb_d  = REG_WRITE_MEM & ~(idle_s & mis_s) & ~timeout_s;
            sel_wb_d = RF_WR_SEL_MEM;
            rd_wb_d  = RD_MEM;
            alu_wb_d = ALU_RESULT_MEM;
            pcn_wb_d = PC_N_MEM;
        end else begin
            rw_wb_d = 1'b0;
        end

        if (ack_s & ~we_q) begin
            ld_wb_d = load_fmt(size_q, zext_q, off_q, DBUS_RDATA);
        end else begin
            ld_wb_d = ld_wb_q;
        end

        mis_err_d = idle_s & mis_s;
        bus_err_d = timeout_s;
    end

    // State, bus request and MEM/WB registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= 10'd0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0000_0000;
            be_q      <= 4'b0000;
            wdata_q   <= 32'h0000_0000;
            off_q     <= 2'b00;
            size_q    <= 2'b00;
            zext_q    <= 1'b0;
            rw_wb_q   <= 1'b0;
            sel_wb_q  <= 1'b0;
            rd_wb_q   <= 5'd0;
            alu_wb_q  <= 32'h0000_0000;
            ld_wb_q   <= 32'h0000_0000;
            pcn_wb_q  <= 32'h0000_0000;
            mis_err_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            off_q     <= off_d;
            size_q    <= size_d;
            zext_q    <= zext_d;
            rw_wb_q   <= rw_wb_d;
            sel_wb_q  <= sel_wb_d;
            rd_wb_q   <= rd_wb_d;
            alu_wb_q  <= alu_wb_d;
            ld_wb_q   <= ld_wb_d;
            pcn_wb_q  <= pcn_wb_d;
            mis_err_q <= mis_err_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign STALL         = stall_s;
    assign DBUS_REQ      = req_q;
    assign DBUS_WE       = we_q;
    assign DBUS_ADDR     = addr_q;
    assign DBUS_BE       = be_q;
    assign DBUS_WDATA    = wdata_q;
    assign REG_WRITE_WB  = rw_wb_q;
    assign RF_WR_SEL_WB  = sel_wb_q;
    assign RD_WB         = rd_wb_q;
    assign ALU_RESULT_WB = alu_wb_q;
    assign LOAD_DATA_WB  = ld_wb_q;
    assign PC_N_WB       = pcn_wb_q;
    assign MISALIGN_ERR  = mis_err_q;
    assign BUS_ERR       = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: a cycle model of the stage rules compared
// every cycle, plus directed loads/stores with hand-computed expectations.
module tb_mem_access_stage;
    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  size;
    logic        sign, rd_in, wr_in, rw_in, sel_in;
    logic [31:0] alu, rs2, pcn;
    logic [4:0]  rd;
    logic        req, we, ack, stall, rw_wb, sel_wb, mis_err, bus_err;
    logic [31:0] addr, wdata, rdata, alu_wb, ld_wb, pcn_wb;
    logic [3:0]  be;
    logic [4:0]  rd_wb;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK(clk), .RST(rst), .SIZE_MEM(size), .SIGN_MEM(sign),
        .MEM_READ_2_MEM(rd_in), .MEM_WRITE_MEM(wr_in), .REG_WRITE_MEM(rw_in),
        .RF_WR_SEL_MEM(sel_in), .ALU_RESULT_MEM(alu), .RS2_MEM(rs2), .RD_MEM(rd),
        .PC_N_MEM(pcn), .DBUS_REQ(req), .DBUS_WE(we), .DBUS_ADDR(addr), .DBUS_BE(be),
        .DBUS_WDATA(wdata), .DBUS_ACK(ack), .DBUS_RDATA(rdata), .STALL(stall),
        .REG_WRITE_WB(rw_wb), .RF_WR_SEL_WB(sel_wb), .RD_WB(rd_wb),
        .ALU_RESULT_WB(alu_wb), .LOAD_DATA_WB(ld_wb), .PC_N_WB(pcn_wb),
        .MISALIGN_ERR(mis_err), .BUS_ERR(bus_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Bus responder: ACK after ack_delay REQ cycles; ack_force injects a stray ACK.
    int          ack_delay = 0;
    int          resp_cnt = 0;
    logic        ack_resp = 1'b0;
    logic        ack_force = 1'b0;
    logic [31:0] resp_rdata = 32'h0;
    assign ack   = ack_resp | ack_force;
    assign rdata = resp_rdata;

    initial forever begin
        @(posedge clk); #1;
        if (req === 1'b1) begin
            ack_resp = (resp_cnt == ack_delay);
            resp_cnt++;
        end else begin
            ack_resp = 1'b0;
            resp_cnt = 0;
        end
    end

    // Bus monitor: counts REQ cycles and captures what was presented.
    int          req_total = 0;
    logic [31:0] cap_addr = 32'h0, cap_wdata = 32'h0;
    logic [3:0]  cap_be = 4'h0;
    logic        cap_we = 1'b0;
    initial forever begin
        @(negedge clk);
        if (req === 1'b1) begin
            req_total++;
            cap_addr  = addr;
            cap_wdata = wdata;
            cap_be    = be;
            cap_we    = we;
        end
    end

    // ---------------- behavioural model ----------------
    bit          m_valid = 0, m_busy = 0;
    int          m_waited = 0;
    logic        m_req = 0, m_we = 0, m_zext = 0, m_rw = 0, m_sel = 0, m_mis = 0, m_berr = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_alu = 0, m_ld = 0, m_pcn = 0;
    logic [3:0]  m_be = 0;
    logic [1:0]  m_off = 0, m_size = 0;
    logic [4:0]  m_rd = 0;
    bit          m_acc, m_misn, m_ack, m_tmo, m_stl;

    function automatic bit is_acc();
        return (rd_in | wr_in) == 1'b1;
    endfunction

    function automatic bit is_mis();
        return is_acc() && (size == 2'd3 || (size == 2'd1 && alu[0]) || (size == 2'd2 && alu[1:0] != 2'd0));
    endfunction

    function automatic bit exp_stall();
        if (!m_busy) return is_acc() && !is_mis();
        return (ack !== 1'b1) && (m_waited + 1 != TO);
    endfunction

    function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] sz, input logic z);
        logic [31:0] lane;
        lane = w >> (8 * off);
        if (sz == 2'd0) return z ? (lane & 32'h0000_00FF) : 32'($signed(lane[7:0]));
        if (sz == 2'd1) return z ? (lane & 32'h0000_FFFF) : 32'($signed(lane[15:0]));
        return w;
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_valid = 1; m_busy = 0; m_waited = 0;
            m_req = 0; m_we = 0; m_addr = 0; m_be = 0; m_wdata = 0; m_off = 0; m_size = 0; m_zext = 0;
            m_rw = 0; m_sel = 0; m_rd = 0; m_alu = 0; m_ld = 0; m_pcn = 0; m_mis = 0; m_berr = 0;
        end else begin
            m_acc  = is_acc();
            m_misn = is_mis();
            m_ack  = m_busy && (ack === 1'b1);
            m_tmo  = m_busy && (ack !== 1'b1) && (m_waited + 1 == TO);
            m_stl  = exp_stall();
            m_mis  = !m_busy && m_misn;
            m_berr = m_tmo;
            if (!m_stl) begin
                m_rw = rw_in && !m_mis && !m_tmo;
                m_sel = sel_in; m_rd = rd; m_alu = alu; m_pcn = pcn;
            end else begin
                m_rw = 0;
            end
            if (m_ack && !m_we) m_ld = fmt_load(rdata, m_off, m_size, m_zext);
            if (!m_busy && m_acc && !m_misn) begin
                m_busy = 1; m_waited = 0; m_req = 1; m_we = wr_in;
                m_addr = alu & 32'hFFFF_FFFC;
                m_off = alu[1:0]; m_size = size; m_zext = sign;
                if (size == 2'd0) begin
                    m_be = 4'b0001 << alu[1:0];
                    m_wdata = {24'h0, rs2[7:0]} * 32'h0101_0101;
                end else if (size == 2'd1) begin
                    m_be = 4'b0011 << (alu[1:0] & 2'b10);
                    m_wdata = {16'h0, rs2[15:0]} * 32'h0001_0001;
                end else begin
                    m_be = 4'hF;
                    m_wdata = rs2;
                end
            end else if (m_ack || m_tmo) begin
                m_busy = 0; m_req = 0;
            end else if (m_busy) begin
                m_waited++;
            end
        end
    end

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("stall", 32'(stall), 32'(exp_stall()));
            chk("req", 32'(req), 32'(m_req));
            if (m_req) begin
                chk("we", 32'(we), 32'(m_we));
                chk("addr", addr, m_addr);
                chk("be", 32'(be), 32'(m_be));
                if (m_we) chk("wdata", wdata, m_wdata);
            end
            chk("rw_wb", 32'(rw_wb), 32'(m_rw));
            chk("sel_wb", 32'(sel_wb), 32'(m_sel));
            chk("rd_wb", 32'(rd_wb), 32'(m_rd));
            chk("alu_wb", alu_wb, m_alu);
            chk("ld_wb", ld_wb, m_ld);
            chk("pcn_wb", pcn_wb, m_pcn);
            chk("mis_err", 32'(mis_err), 32'(m_mis));
            chk("bus_err", 32'(bus_err), 32'(m_berr));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set_idle();
        rd_in = 0; wr_in = 0; rw_in = 0; sel_in = 0; size = 2'd0; sign = 0;
        alu = 32'h0; rs2 = 32'h0; rd = 5'd0; pcn = 32'h0;
    endtask

    // Present one instruction (called #1 after a rising edge), hold it while STALL is
    // high, and return #1 after the edge on which it leaves the stage.
    task automatic op(input bit r, input bit w, input logic [1:0] sz, input bit sg,
                      input logic [31:0] a, input logic [31:0] d, input logic [4:0] dst,
                      input bit rw, output int stalls);
        bit done;
        rd_in = r; wr_in = w; size = sz; sign = sg; alu = a; rs2 = d; rd = dst;
        rw_in = rw; sel_in = r; pcn = a + 32'd4;
        stalls = 0;
        done = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (stall !== 1'b1) begin
                done = 1;
                break;
            end
            stalls++;
            @(posedge clk); #1;
        end
        if (!done) begin
            errors++; checks++;
            $display("FAIL op_bound: STALL still high after 40 cycles, addr %h", a);
        end
        @(posedge clk); #1;
        set_idle();
    endtask

    int st, r0;

    initial begin
        set_idle();
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("reset_req", 32'(req), 32'h0);
        chk("reset_ld", ld_wb, 32'h0);
        chk("reset_stall", 32'(stall), 32'h0);

        // Non-memory passthrough
        op(0, 0, 2'd0, 0, 32'h55, 32'h0, 5'd3, 1, st);
        chk("pass_stalls", st, 0);
        chk("pass_rd", 32'(rd_wb), 32'd3);
        chk("pass_alu", alu_wb, 32'h55);
        chk("pass_pcn", pcn_wb, 32'h59);
        chk("pass_rw", 32'(rw_wb), 32'h1);

        // LW 0x100, immediate ACK
        resp_rdata = 32'hDEAD_BEEF; ack_delay = 0; r0 = req_total;
        op(1, 0, 2'd2, 0, 32'h100, 32'h0, 5'd5, 1, st);
        chk("lw_stalls", st, 1);
        chk("lw_reqcyc", req_total - r0, 1);
        chk("lw_addr", cap_addr, 32'h100);
        chk("lw_be", 32'(cap_be), 32'hF);
        chk("lw_we", 32'(cap_we), 32'h0);
        chk("lw_data", ld_wb, 32'hDEAD_BEEF);
        chk("lw_rw", 32'(rw_wb), 32'h1);

        // LB / LBU at 0x103
        resp_rdata = 32'h80FF_0000;
        op(1, 0, 2'd0, 0, 32'h103, 32'h0, 5'd6, 1, st);
        chk("lb_stalls", st, 1);
        chk("lb_be", 32'(cap_be), 32'h8);
        chk("lb_data", ld_wb, 32'hFFFF_FF80);
        op(1, 0, 2'd0, 1, 32'h103, 32'h0, 5'd6, 1, st);
        chk("lbu_data", ld_wb, 32'h0000_0080);

        // SH 0x202, ACK on the 4th REQ cycle
        ack_delay = 3; r0 = req_total;
        op(0, 1, 2'd1, 0, 32'h202, 32'h1234_ABCD, 5'd0, 0, st);
        chk("sh_stalls", st, 4);
        chk("sh_reqcyc", req_total - r0, 4);
        chk("sh_addr", cap_addr, 32'h200);
        chk("sh_be", 32'(cap_be), 32'hC);
        chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
        chk("sh_we", 32'(cap_we), 32'h1);
        chk("sh_ld_hold", ld_wb, 32'h0000_0080);

        // Misaligned LW
        ack_delay = 0; r0 = req_total;
        op(1, 0, 2'd2, 0, 32'h101, 32'h0, 5'd7, 1, st);
        chk("mis_stalls", st, 0);
        chk("mis_reqcyc", req_total - r0, 0);
        chk("mis_pulse", 32'(mis_err), 32'h1);
        chk("mis_rw", 32'(rw_wb), 32'h0);
        @(posedge clk); #1;
        chk("mis_pulse_end", 32'(mis_err), 32'h0);

        // Timeout with no ACK
        ack_delay = 100; r0 = req_total;
        op(1, 0, 2'd2, 0, 32'h300, 32'h0, 5'd9, 1, st);
        chk("to_stalls", st, 4);
        chk("to_reqcyc", req_total - r0, 4);
        chk("to_buserr", 32'(bus_err), 32'h1);
        chk("to_req", 32'(req), 32'h0);
        chk("to_rw", 32'(rw_wb), 32'h0);
        @(posedge clk); #1;
        chk("to_buserr_end", 32'(bus_err), 32'h0);

        // ACK in the timeout cycle wins
        ack_delay = 3; resp_rdata = 32'h0BAD_F00D;
        op(1, 0, 2'd2, 0, 32'h304, 32'h0, 5'd10, 1, st);
        chk("ackto_stalls", st, 4);
        chk("ackto_buserr", 32'(bus_err), 32'h0);
        chk("ackto_data", ld_wb, 32'h0BAD_F00D);
        chk("ackto_rw", 32'(rw_wb), 32'h1);

        // Reset during BUSY, then a stray ACK
        ack_delay = 100;
        rd_in = 1; rw_in = 1; size = 2'd2; alu = 32'h400; rd = 5'd11; pcn = 32'h404;
        repeat (2) begin @(posedge clk); #1; end
        chk("rstbusy_req_before", 32'(req), 32'h1);
        rst = 1; set_idle();
        @(posedge clk); #1;
        rst = 0;
        chk("rstbusy_req", 32'(req), 32'h0);
        chk("rstbusy_ld", ld_wb, 32'h0);
        chk("rstbusy_alu", alu_wb, 32'h0);
        chk("rstbusy_rd", 32'(rd_wb), 32'h0);
        ack_force = 1;
        @(posedge clk); #1;
        ack_force = 0;
        chk("stray_ack_req", 32'(req), 32'h0);
        chk("stray_ack_ld", ld_wb, 32'h0);
        chk("stray_ack_stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        chk("stray_ack_req2", 32'(req), 32'h0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
